act_buffer_ring_ctrl: RTL and testbench

Control block for the activation memory's multi-buffering. It generalises fixed two-buffer double buffering to a ring of NUM_BUFFERS equal regions. It hands regions to the activation producer (write side: external port or PE-array output) and the consumer (array input fetch) in strict ring order. It generates row write addresses, records per-buffer fill length, and flags protocol and overflow errors. It has no datapath; it drives the SRAM bank address and select logic of the activation memory.

---
 rtl/act_buffer_ring_ctrl.sv | 148 ++++++++++++++
 tb/tb_act_buffer_ring_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/act_buffer_ring_ctrl.sv
// Ring-of-regions controller for the activation memory: hands regions to the
// producer and consumer in strict ring order and produces SRAM row addresses.
module act_buffer_ring_ctrl #(
  parameter  int NUM_BUFFERS  = 2,
  parameter  int BUFFER_WORDS = 4096,
  localparam int ADDR_WIDTH   = $clog2(NUM_BUFFERS*BUFFER_WORDS),
  localparam int LEN_WIDTH    = $clog2(BUFFER_WORDS)+1,
  localparam int BUF_W        = $clog2(NUM_BUFFERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  output logic                  wr_active,
  output logic [BUF_W-1:0]      wr_buf,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_req,
  output logic                  rd_active,
  output logic [BUF_W-1:0]      rd_buf,
  output logic [ADDR_WIDTH-1:0] rd_base,
  output logic [LEN_WIDTH-1:0]  rd_len,
  input  logic                  rd_release,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_err,
  output logic                  protocol_err
);

  localparam int PTR_W = LEN_WIDTH-1;

  if (NUM_BUFFERS < 2 || NUM_BUFFERS > 4) begin : g_bad_num_buffers
    $error("NUM_BUFFERS must be in 2..4");
  end
  if (BUFFER_WORDS < 2 || (BUFFER_WORDS & (BUFFER_WORDS-1)) != 0) begin : g_bad_buffer_words
    $error("BUFFER_WORDS must be a power of 2");
  end

  typedef enum logic [1:0] {
    ST_FREE,
    ST_FILLING,
    ST_READY,
    ST_DRAINING
  } region_state_t;

  region_state_t          state_q [NUM_BUFFERS];
  region_state_t          state_d [NUM_BUFFERS];
  logic [LEN_WIDTH-1:0]   len_q   [NUM_BUFFERS];
  logic [BUF_W-1:0]       wr_head_q;
  logic [BUF_W-1:0]       rd_head_q;
  logic [PTR_W-1:0]       wr_ptr_q;

  logic                   wr_grant;
  logic                   wr_beat;
  logic                   wr_ovf;
  logic                   wr_close;
  logic                   rd_grant;
  logic                   rd_free;
  logic                   proto_hit;
  logic                   any_free;
  logic                   all_free;
  logic [LEN_WIDTH-1:0]   close_len;

  function automatic logic [BUF_W-1:0] ring_next(input logic [BUF_W-1:0] idx);
    ring_next = (idx == BUF_W'(NUM_BUFFERS-1)) ? '0 : idx + 1'b1;
  endfunction

  assign wr_grant  = wr_req & ~wr_active & (state_q[wr_head_q] == ST_FREE);
  assign wr_beat   = wr_valid & wr_active;
  // The last row of a region closes it whether or not the producer flagged it.
  assign wr_ovf    = wr_beat & ~wr_last & (wr_ptr_q == {PTR_W{1'b1}});
  assign wr_close  = wr_beat & (wr_last | (wr_ptr_q == {PTR_W{1'b1}}));
  assign close_len = LEN_WIDTH'(wr_ptr_q) + LEN_WIDTH'(1);
  assign rd_grant  = rd_req & ~rd_active & (state_q[rd_head_q] == ST_READY);
  assign rd_free   = rd_release & rd_active;
  assign proto_hit = (wr_valid & ~wr_active) | (rd_release & ~rd_active);

  assign wr_addr = ADDR_WIDTH'({wr_buf, wr_ptr_q});
  assign rd_base = ADDR_WIDTH'({rd_buf, {PTR_W{1'b0}}});

  // Each transition is guarded by a distinct source state, so at most one
  // fires per region per cycle.
  always_comb begin
    state_d  = state_q;
    any_free = 1'b0;
    all_free = 1'b1;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (wr_grant && wr_head_q == BUF_W'(i)) state_d[i] = ST_FILLING;
      if (wr_close && wr_buf    == BUF_W'(i)) state_d[i] = ST_READY;
      if (rd_grant && rd_head_q == BUF_W'(i)) state_d[i] = ST_DRAINING;
      if (rd_free  && rd_buf    == BUF_W'(i)) state_d[i] = ST_FREE;
      if (state_d[i] == ST_FREE) any_free = 1'b1;
      else                       all_free = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFFERS; i++) state_q[i] <= ST_FREE;
      wr_head_q    <= '0;
      rd_head_q    <= '0;
      wr_ptr_q     <= '0;
      wr_active    <= 1'b0;
      wr_buf       <= '0;
      rd_active    <= 1'b0;
      rd_buf       <= '0;
      rd_len       <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow_err <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state_q <= state_d;
      full    <= ~any_free;
      empty   <= all_free;

      if (wr_grant) begin
        wr_active <= 1'b1;
        wr_buf    <= wr_head_q;
        wr_ptr_q  <= '0;
        wr_head_q <= ring_next(wr_head_q);
      end else if (wr_close) begin
        wr_active <= 1'b0;
        wr_ptr_q  <= '0;
      end else if (wr_beat) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
      end

      if (rd_grant) begin
        rd_active <= 1'b1;
        rd_buf    <= rd_head_q;
        rd_len    <= len_q[rd_head_q];
        rd_head_q <= ring_next(rd_head_q);
      end else if (rd_free) begin
        rd_active <= 1'b0;
      end

      if (wr_ovf)    overflow_err <= 1'b1;
      if (proto_hit) protocol_err <= 1'b1;
    end
  end

  // Fill lengths are only read back from READY regions, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_close) len_q[wr_buf] <= close_len;
  end

endmodule

// File: tb/tb_act_buffer_ring_ctrl.sv
// Directed bench for act_buffer_ring_ctrl: a 2-region and a 3-region instance
// share the same stimulus; each scenario checks the instance it targets.
module tb_act_buffer_ring_ctrl;

  logic clk = 1'b0;
  logic reset, wr_req, wr_valid, wr_last, rd_req, rd_release;

  logic       w2_active, r2_active, full2, empty2, ovf2, prot2;
  logic [0:0] w2_buf, r2_buf;
  logic [4:0] w2_addr, r2_base, r2_len;

  logic       w3_active, r3_active, full3, empty3, ovf3, prot3;
  logic [1:0] w3_buf, r3_buf;
  logic [5:0] w3_addr, r3_base;
  logic [4:0] r3_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  act_buffer_ring_ctrl #(.NUM_BUFFERS(2), .BUFFER_WORDS(16)) u_dut2 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_active(w2_active), .wr_buf(w2_buf),
    .wr_valid(wr_valid), .wr_last(wr_last), .wr_addr(w2_addr), .rd_req(rd_req),
    .rd_active(r2_active), .rd_buf(r2_buf), .rd_base(r2_base), .rd_len(r2_len),
    .rd_release(rd_release), .full(full2), .empty(empty2), .overflow_err(ovf2),
    .protocol_err(prot2));

  act_buffer_ring_ctrl #(.NUM_BUFFERS(3), .BUFFER_WORDS(16)) u_dut3 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_active(w3_active), .wr_buf(w3_buf),
    .wr_valid(wr_valid), .wr_last(wr_last), .wr_addr(w3_addr), .rd_req(rd_req),
    .rd_active(r3_active), .rd_buf(r3_buf), .rd_base(r3_base), .rd_len(r3_len),
    .rd_release(rd_release), .full(full3), .empty(empty3), .overflow_err(ovf3),
    .protocol_err(prot3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    wr_req = 0; wr_valid = 0; wr_last = 0; rd_req = 0; rd_release = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (w2_active !== 1'b0) begin errors++; $display("FAIL reset_wr_active: got %0d want 0", w2_active); end
    checks++; if (r2_active !== 1'b0) begin errors++; $display("FAIL reset_rd_active: got %0d want 0", r2_active); end
    checks++; if (w2_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", w2_addr); end
    checks++; if (r2_len !== 5'd0 || r2_base !== 5'd0 || r2_buf !== 1'b0) begin errors++; $display("FAIL reset_rd_regs: got len=%0d base=%0d buf=%0d want 0", r2_len, r2_base, r2_buf); end
    checks++; if (full2 !== 1'b0 || empty2 !== 1'b1) begin errors++; $display("FAIL reset_full_empty: got full=%0d empty=%0d want 0/1", full2, empty2); end
    checks++; if (ovf2 !== 1'b0 || prot2 !== 1'b0) begin errors++; $display("FAIL reset_errs: got ovf=%0d prot=%0d want 0/0", ovf2, prot2); end
  endtask

  task automatic test_basic_layer();
    apply_reset();
    wr_req = 1;
    tick();
    wr_req = 0;
    checks++; if (w2_active !== 1'b1 || w2_buf !== 1'b0) begin errors++; $display("FAIL basic_wr_grant: got active=%0d buf=%0d want 1/0", w2_active, w2_buf); end
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_last = (i == 4);
      checks++; if (w2_addr !== 5'(i)) begin errors++; $display("FAIL basic_wr_addr: got %0d want %0d", w2_addr, i); end
      tick();
    end
    wr_valid = 0; wr_last = 0;
    checks++; if (w2_active !== 1'b0 || empty2 !== 1'b0) begin errors++; $display("FAIL basic_close: got active=%0d empty=%0d want 0/0", w2_active, empty2); end
    rd_req = 1;
    tick();
    rd_req = 0;
    checks++; if (r2_active !== 1'b1 || r2_buf !== 1'b0 || r2_base !== 5'd0 || r2_len !== 5'd5) begin errors++; $display("FAIL basic_rd_grant: got active=%0d buf=%0d base=%0d len=%0d want 1/0/0/5", r2_active, r2_buf, r2_base, r2_len); end
    rd_release = 1;
    tick();
    rd_release = 0;
    checks++; if (r2_active !== 1'b0 || empty2 !== 1'b1) begin errors++; $display("FAIL basic_release: got active=%0d empty=%0d want 0/1", r2_active, empty2); end
    checks++; if (r2_len !== 5'd5 || prot2 !== 1'b0) begin errors++; $display("FAIL basic_hold: got len=%0d prot=%0d want 5/0", r2_len, prot2); end
  endtask

  task automatic test_ping_pong();
    apply_reset();
    wr_req = 1;
    tick();
    wr_req = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_last = (i == 2);
      tick();
    end
    wr_valid = 0; wr_last = 0;
    rd_req = 1; wr_req = 1;
    tick();
    rd_req = 0; wr_req = 0;
    checks++; if (r2_active !== 1'b1 || r2_buf !== 1'b0 || r2_len !== 5'd3) begin errors++; $display("FAIL pp_rd0: got active=%0d buf=%0d len=%0d want 1/0/3", r2_active, r2_buf, r2_len); end
    checks++; if (w2_active !== 1'b1 || w2_buf !== 1'b1) begin errors++; $display("FAIL pp_wr1: got active=%0d buf=%0d want 1/1", w2_active, w2_buf); end
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1; wr_last = (i == 6);
      checks++; if (w2_addr !== 5'(16 + i) || r2_active !== 1'b1) begin errors++; $display("FAIL pp_wr_addr: got addr=%0d rd_active=%0d want %0d/1", w2_addr, r2_active, 16 + i); end
      tick();
    end
    wr_valid = 0; wr_last = 0;
    rd_release = 1;
    tick();
    rd_release = 0;
    rd_req = 1;
    tick();
    rd_req = 0;
    checks++; if (r2_active !== 1'b1 || r2_buf !== 1'b1 || r2_base !== 5'd16 || r2_len !== 5'd7) begin errors++; $display("FAIL pp_rd1: got active=%0d buf=%0d base=%0d len=%0d want 1/1/16/7", r2_active, r2_buf, r2_base, r2_len); end
  endtask

  task automatic test_full_stall();
    apply_reset();
    wr_req = 1;
    tick();
    wr_req = 0;
    wr_valid = 1; wr_last = 0; tick();
    wr_last = 1; tick();
    wr_valid = 0; wr_last = 0;
    wr_req = 1;
    tick();
    checks++; if (w2_active !== 1'b1 || w2_buf !== 1'b1) begin errors++; $display("FAIL full_wr1: got active=%0d buf=%0d want 1/1", w2_active, w2_buf); end
    wr_valid = 1; wr_last = 0; tick();
    wr_last = 1; tick();
    wr_valid = 0; wr_last = 0;
    repeat (3) tick();
    checks++; if (full2 !== 1'b1 || w2_active !== 1'b0 || prot2 !== 1'b0 || ovf2 !== 1'b0) begin errors++; $display("FAIL full_stall: got full=%0d wr_active=%0d prot=%0d ovf=%0d want 1/0/0/0", full2, w2_active, prot2, ovf2); end
    rd_req = 1;
    tick();
    rd_req = 0;
    checks++; if (r2_active !== 1'b1 || r2_buf !== 1'b0 || full2 !== 1'b1) begin errors++; $display("FAIL full_rd0: got active=%0d buf=%0d full=%0d want 1/0/1", r2_active, r2_buf, full2); end
    rd_release = 1;
    tick();
    rd_release = 0;
    checks++; if (w2_active !== 1'b0 || full2 !== 1'b0) begin errors++; $display("FAIL full_n1: got wr_active=%0d full=%0d want 0/0", w2_active, full2); end
    tick();
    checks++; if (w2_active !== 1'b1 || w2_buf !== 1'b0 || full2 !== 1'b1) begin errors++; $display("FAIL full_n2: got wr_active=%0d buf=%0d full=%0d want 1/0/1", w2_active, w2_buf, full2); end
    wr_req = 0;
  endtask

  task automatic test_overflow();
    apply_reset();
    wr_req = 1;
    tick();
    wr_req = 0;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1; wr_last = 0;
      checks++; if (w2_addr !== 5'(i)) begin errors++; $display("FAIL ovf_addr: got %0d want %0d", w2_addr, i); end
      tick();
    end
    checks++; if (ovf2 !== 1'b1 || w2_active !== 1'b0 || prot2 !== 1'b0) begin errors++; $display("FAIL ovf_close: got ovf=%0d wr_active=%0d prot=%0d want 1/0/0", ovf2, w2_active, prot2); end
    tick();
    wr_valid = 0;
    checks++; if (prot2 !== 1'b1) begin errors++; $display("FAIL ovf_beat17: got prot=%0d want 1", prot2); end
    rd_req = 1;
    tick();
    rd_req = 0;
    checks++; if (r2_len !== 5'd16 || r2_base !== 5'd0) begin errors++; $display("FAIL ovf_len: got len=%0d base=%0d want 16/0", r2_len, r2_base); end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    rd_release = 1;
    tick();
    rd_release = 0;
    wr_req = 1;
    tick();
    wr_req = 0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_last = 0;
      tick();
    end
    wr_valid = 0;
    checks++; if (prot2 !== 1'b1 || w2_addr !== 5'd4) begin errors++; $display("FAIL mid_pre: got prot=%0d addr=%0d want 1/4", prot2, w2_addr); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (empty2 !== 1'b1 || w2_active !== 1'b0 || prot2 !== 1'b0 || ovf2 !== 1'b0) begin errors++; $display("FAIL mid_reset: got empty=%0d wr_active=%0d prot=%0d ovf=%0d want 1/0/0/0", empty2, w2_active, prot2, ovf2); end
    wr_req = 1;
    tick();
    wr_req = 0;
    checks++; if (w2_active !== 1'b1 || w2_buf !== 1'b0 || w2_addr !== 5'd0) begin errors++; $display("FAIL mid_regrant: got active=%0d buf=%0d addr=%0d want 1/0/0", w2_active, w2_buf, w2_addr); end
  endtask

  task automatic test_wrap3();
    logic [1:0] exp_buf [4];
    logic [5:0] exp_base [4];
    exp_buf  = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_base = '{6'd0, 6'd16, 6'd32, 6'd0};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      wr_req = 1;
      tick();
      wr_req = 0;
      checks++; if (w3_active !== 1'b1 || w3_buf !== exp_buf[k]) begin errors++; $display("FAIL wrap_wr_buf: got active=%0d buf=%0d want 1/%0d", w3_active, w3_buf, exp_buf[k]); end
      for (int i = 0; i < k + 2; i++) begin
        wr_valid = 1; wr_last = (i == k + 1);
        tick();
      end
      wr_valid = 0; wr_last = 0;
      rd_req = 1;
      tick();
      rd_req = 0;
      checks++; if (r3_buf !== exp_buf[k] || r3_base !== exp_base[k] || r3_len !== 5'(k + 2)) begin errors++; $display("FAIL wrap_rd: got buf=%0d base=%0d len=%0d want %0d/%0d/%0d", r3_buf, r3_base, r3_len, exp_buf[k], exp_base[k], k + 2); end
      rd_release = 1;
      tick();
      rd_release = 0;
    end
    checks++; if (empty3 !== 1'b1 || prot3 !== 1'b0 || ovf3 !== 1'b0) begin errors++; $display("FAIL wrap_end: got empty=%0d prot=%0d ovf=%0d want 1/0/0", empty3, prot3, ovf3); end
  endtask

  initial begin
    reset = 1; wr_req = 0; wr_valid = 0; wr_last = 0; rd_req = 0; rd_release = 0;
    test_reset();
    test_basic_layer();
    test_ping_pong();
    test_full_stall();
    test_overflow();
    test_reset_mid_fill();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
